// File: rtl/nasti_arb_pkg.sv
// nasti_arb_pkg: shared types for the NASTI write arbiter.
// FSM states, B response codes, AW control payload layout.
package nasti_arb_pkg;

  localparam int LEN_W    = 8;
  localparam int SIZE_W   = 3;
  localparam int BURST_W  = 2;
  localparam int CACHE_W  = 4;
  localparam int PROT_W   = 3;
  localparam int QOS_W    = 4;
  localparam int REGION_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B
  } arb_state_t;

  // Width-fixed part of a NastiReq AW beat; id/addr/user
  // are sized per instance and carried alongside.
  typedef struct packed {
    logic [LEN_W-1:0]    len;
    logic [SIZE_W-1:0]   size;
    logic [BURST_W-1:0]  burst;
    logic                lock;
    logic [CACHE_W-1:0]  cache;
    logic [PROT_W-1:0]   prot;
    logic [QOS_W-1:0]    qos;
    logic [REGION_W-1:0] region;
  } nasti_aw_ctrl_t;

  // A beat is wrong when last does not land exactly on beat len.
  function automatic logic beat_mismatch(
    input logic [LEN_W-1:0] cnt,
    input logic [LEN_W-1:0] len,
    input logic             last
  );
    return last != (cnt == len);
  endfunction

endpackage

// File: rtl/nasti_rr_arbiter.sv
// nasti_rr_arbiter: combinational round-robin pick.
// req/ptr in; one-hot gnt, binary idx and any out.
module nasti_rr_arbiter
  import nasti_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0]    sum;
  logic [IDX_W-1:0] k;

  // Scan from ptr upward, wrapping at N; first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    k   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end
      k = sum[IDX_W-1:0];
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/nasti_write_arbiter.sv
// nasti_write_arbiter: N write masters share one NASTI write slave.
// Ports: master_aw/w/b_* (sliced per master), slave_aw/w/b_*.
// One transaction in flight; owner keeps W and B until B completes.
// Optional NASTI_WRITE_ARB_BEAT_CHECK_EN adds beat_err and SLVERR.
module nasti_write_arbiter
  import nasti_arb_pkg::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [N_MASTERS*ID_WIDTH-1:0]     master_aw_id,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]   master_aw_addr,
  input  logic [N_MASTERS*LEN_W-1:0]        master_aw_len,
  input  logic [N_MASTERS*SIZE_W-1:0]       master_aw_size,
  input  logic [N_MASTERS*BURST_W-1:0]      master_aw_burst,
  input  logic [N_MASTERS-1:0]              master_aw_lock,
  input  logic [N_MASTERS*CACHE_W-1:0]      master_aw_cache,
  input  logic [N_MASTERS*PROT_W-1:0]       master_aw_prot,
  input  logic [N_MASTERS*QOS_W-1:0]        master_aw_qos,
  input  logic [N_MASTERS*REGION_W-1:0]     master_aw_region,
  input  logic [N_MASTERS*USER_WIDTH-1:0]   master_aw_user,
  input  logic [N_MASTERS-1:0]              master_aw_valid,
  output logic [N_MASTERS-1:0]              master_aw_ready,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]   master_w_data,
  input  logic [N_MASTERS*DATA_WIDTH/8-1:0] master_w_strb,
  input  logic [N_MASTERS-1:0]              master_w_last,
  input  logic [N_MASTERS*USER_WIDTH-1:0]   master_w_user,
  input  logic [N_MASTERS-1:0]              master_w_valid,
  output logic [N_MASTERS-1:0]              master_w_ready,
  output logic [ID_WIDTH-1:0]               master_b_id,
  output logic [1:0]                        master_b_resp,
  output logic [USER_WIDTH-1:0]             master_b_user,
  output logic [N_MASTERS-1:0]              master_b_valid,
  input  logic [N_MASTERS-1:0]              master_b_ready,
  output logic [ID_WIDTH-1:0]               slave_aw_id,
  output logic [ADDR_WIDTH-1:0]             slave_aw_addr,
  output logic [LEN_W-1:0]                  slave_aw_len,
  output logic [SIZE_W-1:0]                 slave_aw_size,
  output logic [BURST_W-1:0]                slave_aw_burst,
  output logic                              slave_aw_lock,
  output logic [CACHE_W-1:0]                slave_aw_cache,
  output logic [PROT_W-1:0]                 slave_aw_prot,
  output logic [QOS_W-1:0]                  slave_aw_qos,
  output logic [REGION_W-1:0]               slave_aw_region,
  output logic [USER_WIDTH-1:0]             slave_aw_user,
  output logic                              slave_aw_valid,
  input  logic                              slave_aw_ready,
  output logic [DATA_WIDTH-1:0]             slave_w_data,
  output logic [DATA_WIDTH/8-1:0]           slave_w_strb,
  output logic                              slave_w_last,
  output logic [USER_WIDTH-1:0]             slave_w_user,
  output logic                              slave_w_valid,
  input  logic                              slave_w_ready,
  input  logic [ID_WIDTH-1:0]               slave_b_id,
  input  logic [1:0]                        slave_b_resp,
  input  logic [USER_WIDTH-1:0]             slave_b_user,
  input  logic                              slave_b_valid,
  output logic                              slave_b_ready
`ifdef NASTI_WRITE_ARB_BEAT_CHECK_EN
  ,
  output logic                              beat_err
`endif
);

  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   aw_id_a   [N_MASTERS];
  logic [ADDR_WIDTH-1:0] aw_addr_a [N_MASTERS];
  logic [USER_WIDTH-1:0] aw_user_a [N_MASTERS];
  nasti_aw_ctrl_t        aw_ctrl_a [N_MASTERS];
  logic [DATA_WIDTH-1:0] w_data_a  [N_MASTERS];
  logic [STRB_W-1:0]     w_strb_a  [N_MASTERS];
  logic [USER_WIDTH-1:0] w_user_a  [N_MASTERS];

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_slice
    assign aw_id_a[g]   = master_aw_id[g*ID_WIDTH +: ID_WIDTH];
    assign aw_addr_a[g] = master_aw_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign aw_user_a[g] = master_aw_user[g*USER_WIDTH +: USER_WIDTH];
    assign aw_ctrl_a[g] = '{
      len:    master_aw_len[g*LEN_W +: LEN_W],
      size:   master_aw_size[g*SIZE_W +: SIZE_W],
      burst:  master_aw_burst[g*BURST_W +: BURST_W],
      lock:   master_aw_lock[g],
      cache:  master_aw_cache[g*CACHE_W +: CACHE_W],
      prot:   master_aw_prot[g*PROT_W +: PROT_W],
      qos:    master_aw_qos[g*QOS_W +: QOS_W],
      region: master_aw_region[g*REGION_W +: REGION_W]
    };
    assign w_data_a[g]  = master_w_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_strb_a[g]  = master_w_strb[g*STRB_W +: STRB_W];
    assign w_user_a[g]  = master_w_user[g*USER_WIDTH +: USER_WIDTH];
  end

  arb_state_t            state;
  logic [IDX_W-1:0]      grant;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      grant_nxt;
  logic [IDX_W-1:0]      arb_idx;
  logic [N_MASTERS-1:0]  grant_oh;
  logic [N_MASTERS-1:0]  arb_gnt;
  logic                  arb_any;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;

  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [USER_WIDTH-1:0] aw_user_q;
  nasti_aw_ctrl_t        aw_ctrl_q;
  logic                  aw_valid_q;

  nasti_rr_arbiter #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (master_aw_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign grant_nxt = (grant == IDX_W'(N_MASTERS - 1))
                   ? '0 : grant + IDX_W'(1);

  // rstn gate keeps aw_ready low while reset is held.
  assign master_aw_ready = (state == S_IDLE && rstn)
                         ? arb_gnt : '0;
  assign aw_hs = (state == S_IDLE) && arb_any;

  assign slave_aw_id     = aw_id_q;
  assign slave_aw_addr   = aw_addr_q;
  assign slave_aw_len    = aw_ctrl_q.len;
  assign slave_aw_size   = aw_ctrl_q.size;
  assign slave_aw_burst  = aw_ctrl_q.burst;
  assign slave_aw_lock   = aw_ctrl_q.lock;
  assign slave_aw_cache  = aw_ctrl_q.cache;
  assign slave_aw_prot   = aw_ctrl_q.prot;
  assign slave_aw_qos    = aw_ctrl_q.qos;
  assign slave_aw_region = aw_ctrl_q.region;
  assign slave_aw_user   = aw_user_q;
  assign slave_aw_valid  = aw_valid_q;

  assign slave_w_data  = w_data_a[grant];
  assign slave_w_strb  = w_strb_a[grant];
  assign slave_w_last  = master_w_last[grant];
  assign slave_w_user  = w_user_a[grant];
  assign slave_w_valid = (state == S_W) && master_w_valid[grant];
  assign master_w_ready = (state == S_W)
                        ? grant_oh & {N_MASTERS{slave_w_ready}}
                        : '0;
  assign w_hs = slave_w_valid && slave_w_ready;

  assign master_b_id    = slave_b_id;
  assign master_b_user  = slave_b_user;
  assign master_b_valid = (state == S_B)
                        ? grant_oh & {N_MASTERS{slave_b_valid}}
                        : '0;
  assign slave_b_ready  = (state == S_B) && master_b_ready[grant];
  assign b_hs = slave_b_valid && slave_b_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      grant      <= '0;
      grant_oh   <= '0;
      rr_ptr     <= '0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_user_q  <= '0;
      aw_ctrl_q  <= '0;
      aw_valid_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (aw_hs) begin
            grant      <= arb_idx;
            grant_oh   <= arb_gnt;
            aw_id_q    <= aw_id_a[arb_idx];
            aw_addr_q  <= aw_addr_a[arb_idx];
            aw_user_q  <= aw_user_a[arb_idx];
            aw_ctrl_q  <= aw_ctrl_a[arb_idx];
            aw_valid_q <= 1'b1;
            state      <= S_AW;
          end
        end
        S_AW: begin
          if (slave_aw_ready) begin
            aw_valid_q <= 1'b0;
            state      <= S_W;
          end
        end
        S_W: begin
          if (w_hs && slave_w_last) begin
            state <= S_B;
          end
        end
        S_B: begin
          if (b_hs) begin
            rr_ptr <= grant_nxt;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NASTI_WRITE_ARB_BEAT_CHECK_EN
  logic [LEN_W-1:0] beat_cnt;
  logic             txn_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
      txn_err  <= 1'b0;
      beat_err <= 1'b0;
    end else if (aw_hs) begin
      beat_cnt <= '0;
      txn_err  <= 1'b0;
    end else if (w_hs) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
      if (beat_mismatch(beat_cnt, aw_ctrl_q.len, slave_w_last)) begin
        txn_err  <= 1'b1;
        beat_err <= 1'b1;
      end
    end
  end

  assign master_b_resp = txn_err ? RESP_SLVERR : slave_b_resp;
`else
  assign master_b_resp = slave_b_resp;
`endif

endmodule

// File: tb/tb_nasti_write_arbiter.sv
// tb_nasti_write_arbiter: directed checks of the write arbiter.
// Two masters; slave side driven by hand.
module tb_nasti_write_arbiter;
  import nasti_arb_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0]  aw_id   [2];
  logic [31:0] aw_addr [2];
  logic [7:0]  aw_len  [2];
  logic [1:0]  aw_valid;
  logic [63:0] w_data  [2];
  logic [1:0]  w_valid;
  logic [1:0]  w_last;

  logic [3:0]   master_aw_id;
  logic [63:0]  master_aw_addr;
  logic [15:0]  master_aw_len;
  logic [5:0]   master_aw_size;
  logic [3:0]   master_aw_burst;
  logic [1:0]   master_aw_lock;
  logic [7:0]   master_aw_cache;
  logic [5:0]   master_aw_prot;
  logic [7:0]   master_aw_qos;
  logic [7:0]   master_aw_region;
  logic [1:0]   master_aw_user;
  logic [1:0]   master_aw_ready;
  logic [127:0] master_w_data;
  logic [15:0]  master_w_strb;
  logic [1:0]   master_w_user;
  logic [1:0]   master_w_ready;
  logic [1:0]   master_b_id;
  logic [1:0]   master_b_resp;
  logic [0:0]   master_b_user;
  logic [1:0]   master_b_valid;
  logic [1:0]   master_b_ready;
  logic [1:0]   slave_aw_id;
  logic [31:0]  slave_aw_addr;
  logic [7:0]   slave_aw_len;
  logic [2:0]   slave_aw_size;
  logic [1:0]   slave_aw_burst;
  logic         slave_aw_lock;
  logic [3:0]   slave_aw_cache;
  logic [2:0]   slave_aw_prot;
  logic [3:0]   slave_aw_qos;
  logic [3:0]   slave_aw_region;
  logic [0:0]   slave_aw_user;
  logic         slave_aw_valid;
  logic         slave_aw_ready;
  logic [63:0]  slave_w_data;
  logic [7:0]   slave_w_strb;
  logic         slave_w_last;
  logic [0:0]   slave_w_user;
  logic         slave_w_valid;
  logic         slave_w_ready;
  logic [1:0]   slave_b_id;
  logic [1:0]   slave_b_resp;
  logic [0:0]   slave_b_user;
  logic         slave_b_valid;
  logic         slave_b_ready;
`ifdef NASTI_WRITE_ARB_BEAT_CHECK_EN
  logic         beat_err;
`endif

  assign master_aw_id     = {aw_id[1], aw_id[0]};
  assign master_aw_addr   = {aw_addr[1], aw_addr[0]};
  assign master_aw_len    = {aw_len[1], aw_len[0]};
  assign master_aw_size   = {3'd3, 3'd3};
  assign master_aw_burst  = {2'd1, 2'd1};
  assign master_aw_lock   = 2'b00;
  assign master_aw_cache  = {4'h5, 4'h3};
  assign master_aw_prot   = {3'd2, 3'd0};
  assign master_aw_qos    = 8'h00;
  assign master_aw_region = 8'h00;
  assign master_aw_user   = 2'b00;
  assign master_w_data    = {w_data[1], w_data[0]};
  assign master_w_strb    = {8'hF0, 8'hFF};
  assign master_w_user    = 2'b00;

  nasti_write_arbiter #(
    .N_MASTERS  (2),
    .ID_WIDTH   (2),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .USER_WIDTH (1)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .master_aw_id     (master_aw_id),
    .master_aw_addr   (master_aw_addr),
    .master_aw_len    (master_aw_len),
    .master_aw_size   (master_aw_size),
    .master_aw_burst  (master_aw_burst),
    .master_aw_lock   (master_aw_lock),
    .master_aw_cache  (master_aw_cache),
    .master_aw_prot   (master_aw_prot),
    .master_aw_qos    (master_aw_qos),
    .master_aw_region (master_aw_region),
    .master_aw_user   (master_aw_user),
    .master_aw_valid  (aw_valid),
    .master_aw_ready  (master_aw_ready),
    .master_w_data    (master_w_data),
    .master_w_strb    (master_w_strb),
    .master_w_last    (w_last),
    .master_w_user    (master_w_user),
    .master_w_valid   (w_valid),
    .master_w_ready   (master_w_ready),
    .master_b_id      (master_b_id),
    .master_b_resp    (master_b_resp),
    .master_b_user    (master_b_user),
    .master_b_valid   (master_b_valid),
    .master_b_ready   (master_b_ready),
    .slave_aw_id      (slave_aw_id),
    .slave_aw_addr    (slave_aw_addr),
    .slave_aw_len     (slave_aw_len),
    .slave_aw_size    (slave_aw_size),
    .slave_aw_burst   (slave_aw_burst),
    .slave_aw_lock    (slave_aw_lock),
    .slave_aw_cache   (slave_aw_cache),
    .slave_aw_prot    (slave_aw_prot),
    .slave_aw_qos     (slave_aw_qos),
    .slave_aw_region  (slave_aw_region),
    .slave_aw_user    (slave_aw_user),
    .slave_aw_valid   (slave_aw_valid),
    .slave_aw_ready   (slave_aw_ready),
    .slave_w_data     (slave_w_data),
    .slave_w_strb     (slave_w_strb),
    .slave_w_last     (slave_w_last),
    .slave_w_user     (slave_w_user),
    .slave_w_valid    (slave_w_valid),
    .slave_w_ready    (slave_w_ready),
    .slave_b_id       (slave_b_id),
    .slave_b_resp     (slave_b_resp),
    .slave_b_user     (slave_b_user),
    .slave_b_valid    (slave_b_valid),
    .slave_b_ready    (slave_b_ready)
`ifdef NASTI_WRITE_ARB_BEAT_CHECK_EN
    ,
    .beat_err         (beat_err)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wbeat(input int m, input int b);
    return {32'(m + 1), 32'(32'hD000 + b)};
  endfunction

  task automatic set_aw(input int m, input logic [1:0] id,
                        input logic [31:0] addr,
                        input logic [7:0] len);
    aw_id[m]    = id;
    aw_addr[m]  = addr;
    aw_len[m]   = len;
    aw_valid[m] = 1'b1;
  endtask

  // Waits for m's grant, then checks the forwarded AW.
  task automatic aw_phase(input int m, input logic [1:0] id,
                          input logic [31:0] addr,
                          input logic [7:0] len);
    logic [1:0] oh;
    logic [3:0] cache;
    logic [2:0] prot;
    int cyc;
    oh = 2'b01 << m;
    cache = (m == 0) ? 4'h3 : 4'h5;
    prot = (m == 0) ? 3'd0 : 3'd2;
    cyc = 0;
    #1;
    while (master_aw_ready[m] !== 1'b1 && cyc < 32) begin
      tick;
      #1;
      cyc++;
    end
    chk("aw_ready_grant", master_aw_ready, oh);
    tick;
    aw_valid[m] = 1'b0;
    #1;
    chk("aw_valid", slave_aw_valid, 1);
    chk("aw_id", slave_aw_id, id);
    chk("aw_addr", slave_aw_addr, addr);
    chk("aw_len", slave_aw_len, len);
    chk("aw_ctrl",
        {slave_aw_size, slave_aw_burst, slave_aw_lock,
         slave_aw_cache, slave_aw_prot, slave_aw_qos,
         slave_aw_region, slave_aw_user},
        {3'd3, 2'd1, 1'b0, cache, prot, 4'd0, 4'd0, 1'b0});
    chk("aw_ready_busy", master_aw_ready, 0);
    chk("w_held_ready", master_w_ready, 0);
    chk("w_held_valid", slave_w_valid, 0);
    slave_aw_ready = 1'b1;
    tick;
    slave_aw_ready = 1'b0;
  endtask

  task automatic w_phase(input int m, input int nbeats,
                         input int lastidx, input bit toggle);
    logic [1:0] oh;
    int beat;
    int cyc;
    oh = 2'b01 << m;
    beat = 0;
    cyc = 0;
    w_valid[m] = 1'b1;
    while (beat < nbeats && cyc < 64) begin
      w_data[m] = wbeat(m, beat);
      w_last[m] = (beat == lastidx);
      slave_w_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      chk("w_valid", slave_w_valid, 1);
      chk("w_ready", master_w_ready, slave_w_ready ? oh : 2'b00);
      chk("w_data", slave_w_data, wbeat(m, beat));
      chk("w_strb", slave_w_strb, (m == 0) ? 8'hFF : 8'hF0);
      chk("w_last", slave_w_last, (beat == lastidx));
      if (slave_w_ready) beat++;
      tick;
      cyc++;
    end
    chk("w_beats", beat, nbeats);
    w_valid[m] = 1'b0;
    w_last[m] = 1'b0;
    slave_w_ready = 1'b0;
  endtask

  task automatic b_phase(input int m, input logic [1:0] id,
                         input logic [1:0] resp,
                         input logic [1:0] exp_resp);
    logic [1:0] oh;
    oh = 2'b01 << m;
    slave_b_valid = 1'b1;
    slave_b_id = id;
    slave_b_resp = resp;
    slave_b_user = 1'b1;
    master_b_ready = ~oh;
    #1;
    chk("b_valid", master_b_valid, oh);
    chk("b_ready_hold", slave_b_ready, 0);
    chk("b_resp", master_b_resp, exp_resp);
    chk("b_id_user", {master_b_id, master_b_user}, {id, 1'b1});
    tick;
    master_b_ready = 2'b11;
    #1;
    chk("b_valid_wait", master_b_valid, oh);
    chk("b_ready", slave_b_ready, 1);
    tick;
    slave_b_valid = 1'b0;
    master_b_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    aw_valid = '0;
    w_valid = '0;
    w_last = '0;
    for (int m = 0; m < 2; m++) begin
      aw_id[m] = '0;
      aw_addr[m] = '0;
      aw_len[m] = '0;
      w_data[m] = 64'hBAD0 + 64'(m);
    end
    master_b_ready = '0;
    slave_aw_ready = 1'b0;
    slave_w_ready = 1'b0;
    slave_b_valid = 1'b0;
    slave_b_id = '0;
    slave_b_resp = '0;
    slave_b_user = '0;

    // Reset state, with master 0 already requesting.
    set_aw(0, 2'd2, 32'h0000_1000, 8'd3);
    w_valid[0] = 1'b1;
    w_data[0] = wbeat(0, 0);
    tick;
    tick;
    chk("rst_aw_ready", master_aw_ready, 0);
    chk("rst_aw_valid", slave_aw_valid, 0);
    chk("rst_w_valid", slave_w_valid, 0);
    chk("rst_w_ready", master_w_ready, 0);
    chk("rst_b_valid", master_b_valid, 0);
    chk("rst_b_ready", slave_b_ready, 0);
    rstn = 1'b1;

    // Single master 0, 4 beats, W raised before grant.
    aw_phase(0, 2'd2, 32'h0000_1000, 8'd3);
    w_phase(0, 4, 3, 1'b0);
    b_phase(0, 2'd2, RESP_OKAY, RESP_OKAY);

    // Master 1 mid-W, then reset.
    set_aw(1, 2'd1, 32'h0000_2000, 8'd3);
    aw_phase(1, 2'd1, 32'h0000_2000, 8'd3);
    w_valid[1] = 1'b1;
    w_data[1] = wbeat(1, 0);
    slave_w_ready = 1'b1;
    #1;
    chk("pre_rst_w_valid", slave_w_valid, 1);
    tick;
    set_aw(0, 2'd0, 32'h0000_3000, 8'd1);
    set_aw(1, 2'd3, 32'h0000_4000, 8'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_w_valid", slave_w_valid, 0);
    chk("mid_rst_w_ready", master_w_ready, 0);
    chk("mid_rst_aw_valid", slave_aw_valid, 0);
    chk("mid_rst_aw_ready", master_aw_ready, 0);
    chk("mid_rst_b_valid", master_b_valid, 0);
    w_valid[1] = 1'b0;
    slave_w_ready = 1'b0;
    tick;
    rstn = 1'b1;

    // Both request after reset: pointer is 0, so 0 then 1.
    aw_phase(0, 2'd0, 32'h0000_3000, 8'd1);
    w_phase(0, 2, 1, 1'b0);
    b_phase(0, 2'd0, RESP_OKAY, RESP_OKAY);
    aw_phase(1, 2'd3, 32'h0000_4000, 8'd0);
    w_phase(1, 1, 0, 1'b0);
    b_phase(1, 2'd3, RESP_EXOKAY, RESP_EXOKAY);

    // Master 0 re-requests at once; waiting master 1 goes next.
    set_aw(0, 2'd1, 32'h0000_5000, 8'd0);
    set_aw(1, 2'd2, 32'h0000_6000, 8'd3);
    aw_phase(0, 2'd1, 32'h0000_5000, 8'd0);
    w_phase(0, 1, 0, 1'b0);
    b_phase(0, 2'd1, RESP_OKAY, RESP_OKAY);
    set_aw(0, 2'd2, 32'h0000_7000, 8'd2);
    aw_phase(1, 2'd2, 32'h0000_6000, 8'd3);
    w_valid[0] = 1'b1;
    w_data[0] = 64'hBAD;
    w_phase(1, 4, 3, 1'b1);
    b_phase(1, 2'd2, 2'b11, 2'b11);
    aw_phase(0, 2'd2, 32'h0000_7000, 8'd2);
    w_phase(0, 3, 2, 1'b0);
    b_phase(0, 2'd2, RESP_OKAY, RESP_OKAY);

`ifdef NASTI_WRITE_ARB_BEAT_CHECK_EN
    chk("beat_err_clean", beat_err, 0);
    set_aw(0, 2'd1, 32'h0000_8000, 8'd3);
    aw_phase(0, 2'd1, 32'h0000_8000, 8'd3);
    w_phase(0, 3, 2, 1'b0);
    b_phase(0, 2'd1, RESP_OKAY, RESP_SLVERR);
    chk("beat_err_set", beat_err, 1);
    set_aw(1, 2'd0, 32'h0000_9000, 8'd1);
    aw_phase(1, 2'd0, 32'h0000_9000, 8'd1);
    w_phase(1, 2, 1, 1'b0);
    b_phase(1, 2'd0, RESP_OKAY, RESP_OKAY);
    chk("beat_err_sticky", beat_err, 1);
`endif

    tick;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nasti_write_arbiter.md
Name: nasti_write_arbiter

Overview:
- Shares one NASTI write slave port (typically the master side of a nasti_narrower_writer) between N_MASTERS write requesters.
- Round-robin arbitration on AW. The granted master owns the W and B channels until its B response completes.
- One outstanding write transaction at a time, so W data is never interleaved and B routing is unambiguous.

Parameters:
N_MASTERS, 2, number of requesting masters (2..8)
ID_WIDTH, 2, NASTI ID width
ADDR_WIDTH, 32, address width
DATA_WIDTH, 64, W data width
USER_WIDTH, 1, USER field width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
master_aw_{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  in  N_MASTERS*field  AW payload; master i in slice i
master_aw_valid  in  N_MASTERS  per-master AW valid
master_aw_ready  out  N_MASTERS  per-master AW ready
master_w_{data,strb,last,user}  in  N_MASTERS*field  W payload, sliced per master
master_w_valid  in  N_MASTERS  W valid
master_w_ready  out  N_MASTERS  W ready
master_b_{id,resp,user}  out  field (broadcast)  B payload from slave (resp may be overridden, see Optional Feature)
master_b_valid  out  N_MASTERS  B valid, one-hot to the owner
master_b_ready  in  N_MASTERS  B ready
slave_aw_{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}  out  field  forwarded AW
slave_aw_ready  in  1
slave_w_{data,strb,last,user,valid}  out  field  forwarded W
slave_w_ready  in  1
slave_b_{id,resp,user,valid}  in  field
slave_b_ready  out  1

Behaviour:
- State machine S_IDLE, S_AW, S_W, S_B. Reset: S_IDLE, grant=0, rr_ptr=0. All valid/ready outputs are 0 at reset.
- S_IDLE:
  - Pick the first requesting master at or after rr_ptr (modulo N_MASTERS).
  - Assert master_aw_ready only for that master, in the same cycle (combinational).
  - On handshake: latch the AW payload and grant; go to S_AW.
  - No requests: stay in S_IDLE.
- S_AW: slave_aw_valid=1 from the registered payload, unmodified (ID passes through). On slave_aw_ready: go to S_W.
- S_W:
  - slave_w_* and slave_w_valid are muxed from master[grant].
  - master_w_ready[grant] = slave_w_ready; all others are 0.
  - A slave_w handshake with slave_w_last=1 moves to S_B.
- S_B:
  - slave_b_valid drives master_b_valid[grant] only; slave_b_ready = master_b_ready[grant].
  - On handshake: rr_ptr <= grant+1, wrapping to 0 at N_MASTERS; go to S_IDLE.
- Latency: at least 1 idle cycle between transactions; AW reaches the slave 1 cycle after the master handshake.
- W valid asserted before AW is granted: held off (ready=0) and never dropped.
- Reset mid-transaction: returns to S_IDLE, all valids drop. No transaction recovery.
- Simultaneous requests: strict round robin. A master re-requesting right after its own completion yields to any waiting master.

Optional Feature:
- Macro NASTI_WRITE_ARB_BEAT_CHECK_EN.
- When defined:
  - An 8-bit beat counter (cleared on AW grant) counts forwarded W beats.
  - If slave_w_last coincides with count != latched len, or count reaches len without last, then master_b_resp is forced to 2'b10 (SLVERR) for that transaction.
  - Extra output port beat_err (1 bit), sticky, cleared only by reset.
  - The W stream is not altered.
- When undefined: no counter, no beat_err port, B resp passes through unchanged.

Decomposition:
- Package nasti_arb_pkg:
  - state enum
  - resp constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - NastiReq-style AW payload struct, reused from the shared request typedef
- Sub-module nasti_rr_arbiter: request vector and pointer in, one-hot grant plus index out, purely combinational. Unit-testable alone.

Test Plan:
- Single master 0 writes len=3 (4 beats) -> slave sees identical AW in 1 cycle, 4 W beats, B OKAY routed only to master_b_valid[0].
- Masters 0 and 1 request in the same cycle, rr_ptr=0 -> master 0 served first; master 1 granted in the next S_IDLE, aw_ready[1]=0 until then.
- Master 0 back-to-back requests while master 1 waits -> order 0,1,0. Never 0,0.
- slave_w_ready toggles every other cycle -> master_w_ready[grant] mirrors it, all other w_ready=0, no beat lost or duplicated.
- rstn pulsed low during S_W -> all valids 0 immediately, state S_IDLE, next grant comes from rr_ptr=0.
- With NASTI_WRITE_ARB_BEAT_CHECK_EN: len=3 but w_last on beat 2 -> master_b_resp=2'b10, beat_err=1 and sticky.
